i2s_clock_ws_gen: RTL and testbench

Clock and word-select generation block for the I2S transceiver. It divides the fast system clock `wclk` into the serial bit clock `sclk`, generates the I2S word-select (`ws`) that toggles once per channel word, and produces `ws_change`, a one-bit-period strobe marking each channel boundary. The serial FIFOs use `ws_change` as their read/write enable. All registers run in the `wclk` domain; `sclk` is a generated output and never clocks logic inside this block.

---
 rtl/i2s_clock_ws_gen_if.sv | 28 ++
 rtl/i2s_clock_ws_gen.sv | 78 +++++++
 tb/tb_i2s_clock_ws_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_clock_ws_gen_if.sv
// Control and clock/word-select bundle between the I2S clock generator and its consumers.
// The generator drives sclk/ws/ws_change; the controller drives en, N and frame_size.
interface i2s_clock_ws_gen_if;
  logic       en;
  logic [5:0] N;
  logic       frame_size;
  logic       sclk;
  logic       ws;
  logic       ws_change;

  modport master (
    input  en,
    input  N,
    input  frame_size,
    output sclk,
    output ws,
    output ws_change
  );

  modport slave (
    output en,
    output N,
    output frame_size,
    input  sclk,
    input  ws,
    input  ws_change
  );
endinterface

// File: rtl/i2s_clock_ws_gen.sv
// I2S bit clock divider, word-select generator and channel-boundary strobe.
// Everything runs on wclk; sclk is only an output and never clocks logic here.
module i2s_clock_ws_gen (
  input  logic                  wclk,
  input  logic                  rst_,
  i2s_clock_ws_gen_if.master    bus
);

  logic [5:0] div_cnt;
  logic [5:0] div_lim;
  logic [4:0] bit_cnt;
  logic [4:0] bit_lim;
  logic       sclk_r;
  logic       ws_r;
  logic       ws_q;
  logic       ws_change_r;
  logic       div_wrap;
  logic       rise_stb;
  logic       fall_stb;

  // N of 0 behaves like N of 1, so the compare limit never underflows.
  always_comb begin
    div_lim  = (bus.N == 6'd0) ? 6'd0 : (bus.N - 6'd1);
    bit_lim  = bus.frame_size ? 5'd31 : 5'd15;
    div_wrap = (div_cnt >= div_lim);
    rise_stb = bus.en & div_wrap & ~sclk_r;
    fall_stb = bus.en & div_wrap &  sclk_r;
  end

  // Divider: the forced low while disabled is not a counted fall.
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      div_cnt <= 6'd0;
      sclk_r  <= 1'b0;
    end else if (!bus.en) begin
      div_cnt <= 6'd0;
      sclk_r  <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= 6'd0;
      sclk_r  <= ~sclk_r;
    end else begin
      div_cnt <= div_cnt + 6'd1;
    end
  end

  // Word select; >= lets a 32->16 switch past bit 15 close the word at the next fall.
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      bit_cnt <= 5'd0;
      ws_r    <= 1'b0;
    end else if (fall_stb) begin
      if (bit_cnt >= bit_lim) begin
        bit_cnt <= 5'd0;
        ws_r    <= ~ws_r;
      end else begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  // Boundary strobe spans one full sclk period, rise to rise.
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      ws_q        <= 1'b0;
      ws_change_r <= 1'b0;
    end else if (!bus.en) begin
      ws_change_r <= 1'b0;
    end else if (rise_stb) begin
      ws_change_r <= (ws_r != ws_q);
      ws_q        <= ws_r;
    end
  end

  assign bus.sclk      = sclk_r;
  assign bus.ws        = ws_r;
  assign bus.ws_change = ws_change_r;

endmodule

// File: tb/tb_i2s_clock_ws_gen.sv
// Bench for i2s_clock_ws_gen: fixed vectors, corner sequences and a randomized run
// against a cycle-count arithmetic model of the divider and word counter.
module tb_i2s_clock_ws_gen;

  logic wclk;
  logic rst_;
  i2s_clock_ws_gen_if bus ();

  i2s_clock_ws_gen dut (
    .wclk (wclk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] n;
    logic       fs;
    int         t;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  // model state: enabled edges since enable, falls since last ws toggle
  int m_t;
  int m_n;
  int m_falls;
  bit m_ws;
  bit m_wsq;
  bit m_wc;

  function automatic logic [2:0] outs();
    return {bus.sclk, bus.ws, bus.ws_change};
  endfunction

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {sclk,ws,ws_change} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    bus.en = 1'b0;
    rst_   = 1'b0;
    @(negedge wclk);
    rst_   = 1'b1;
    m_t = 0; m_n = 1; m_falls = 0; m_ws = 0; m_wsq = 0; m_wc = 0;
  endtask

  task automatic model_edge(input bit en, input int n_in, input bit fs);
    int len;
    m_n = (n_in == 0) ? 1 : n_in;
    len = fs ? 32 : 16;
    if (!en) begin
      m_t  = 0;
      m_wc = 0;
    end else begin
      m_t++;
      if (m_t % m_n == 0) begin
        if (((m_t / m_n) % 2) == 1) begin
          m_wc  = (m_ws != m_wsq);
          m_wsq = m_ws;
        end else begin
          m_falls++;
          if (m_falls >= len) begin
            m_ws    = ~m_ws;
            m_falls = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [2:0] model_outs();
    logic s;
    s = (((m_t / m_n) % 2) == 1);
    return {s, m_ws, m_wc};
  endfunction

  initial begin
    bus.en = 1'b0;
    bus.N = 6'd2;
    bus.frame_size = 1'b0;
    rst_ = 1'b0;
    #1;
    check3("reset_state", outs(), 3'b000);

    vecs.push_back('{6'd2,  1'b0, 1,   3'b000});
    vecs.push_back('{6'd2,  1'b0, 2,   3'b100});
    vecs.push_back('{6'd2,  1'b0, 3,   3'b100});
    vecs.push_back('{6'd2,  1'b0, 4,   3'b000});
    vecs.push_back('{6'd2,  1'b0, 63,  3'b100});
    vecs.push_back('{6'd2,  1'b0, 64,  3'b010});
    vecs.push_back('{6'd2,  1'b0, 66,  3'b111});
    vecs.push_back('{6'd2,  1'b0, 69,  3'b011});
    vecs.push_back('{6'd2,  1'b0, 70,  3'b110});
    vecs.push_back('{6'd2,  1'b0, 128, 3'b000});
    vecs.push_back('{6'd2,  1'b0, 130, 3'b101});
    vecs.push_back('{6'd5,  1'b0, 4,   3'b000});
    vecs.push_back('{6'd5,  1'b0, 5,   3'b100});
    vecs.push_back('{6'd5,  1'b0, 9,   3'b100});
    vecs.push_back('{6'd5,  1'b0, 10,  3'b000});
    vecs.push_back('{6'd5,  1'b0, 15,  3'b100});
    vecs.push_back('{6'd0,  1'b0, 1,   3'b100});
    vecs.push_back('{6'd0,  1'b0, 2,   3'b000});
    vecs.push_back('{6'd0,  1'b0, 31,  3'b100});
    vecs.push_back('{6'd0,  1'b0, 32,  3'b010});
    vecs.push_back('{6'd0,  1'b0, 33,  3'b111});
    vecs.push_back('{6'd2,  1'b1, 127, 3'b100});
    vecs.push_back('{6'd2,  1'b1, 128, 3'b010});
    vecs.push_back('{6'd2,  1'b1, 130, 3'b111});
    vecs.push_back('{6'd2,  1'b1, 134, 3'b110});
    vecs.push_back('{6'd63, 1'b0, 62,  3'b000});
    vecs.push_back('{6'd63, 1'b0, 63,  3'b100});

    foreach (vecs[i]) begin
      do_reset();
      bus.N = vecs[i].n;
      bus.frame_size = vecs[i].fs;
      bus.en = 1'b1;
      repeat (vecs[i].t) step();
      check3($sformatf("vec%0d_N%0d_fs%0d_t%0d", i, vecs[i].n, vecs[i].fs, vecs[i].t),
             outs(), vecs[i].exp);
    end

    // enable dropped after 7 falls with sclk high; resume must finish the word
    begin
      int falls;
      bit prev;
      bit toggled;
      do_reset();
      bus.N = 6'd2; bus.frame_size = 1'b0; bus.en = 1'b1;
      repeat (30) step();
      check3("gate_before_drop", outs(), 3'b100);
      bus.en = 1'b0;
      step();
      check3("gate_drop_next", outs(), 3'b000);
      repeat (3) step();
      check3("gate_idle_hold", outs(), 3'b000);
      bus.en = 1'b1;
      falls = 0; prev = 1'b0; toggled = 1'b0;
      for (int i = 0; i < 200 && !toggled; i++) begin
        step();
        if (prev && !bus.sclk) falls++;
        if (bus.ws) toggled = 1'b1;
        prev = bus.sclk;
      end
      check_int("gate_resume_toggled", int'(toggled), 1);
      // 7 falls were already counted before the drop; the toggle lands on the 16th
      check_int("gate_resume_falls", falls, 16 - 7);
    end

    // 32 -> 16 switch after 20 falls closes the word at the next fall
    do_reset();
    bus.N = 6'd2; bus.frame_size = 1'b1; bus.en = 1'b1;
    repeat (80) step();
    check3("frame_sw_before", outs(), 3'b000);
    bus.frame_size = 1'b0;
    repeat (3) step();
    check3("frame_sw_pre_fall", outs(), 3'b100);
    step();
    check3("frame_sw_toggle", outs(), 3'b010);

    // asynchronous reset while sclk, ws and ws_change are all high
    do_reset();
    bus.N = 6'd2; bus.frame_size = 1'b0; bus.en = 1'b1;
    repeat (66) step();
    check3("rst_mid_before", outs(), 3'b111);
    #2 rst_ = 1'b0;
    #1 check3("rst_mid_async", outs(), 3'b000);
    step();
    check3("rst_mid_held", outs(), 3'b000);
    @(negedge wclk);
    rst_ = 1'b1;

    // strobe width and one pulse per word as seen by a falling-sclk sampler
    begin
      int pulses;
      int hi;
      bit prev_s;
      bit prev_w;
      do_reset();
      bus.N = 6'd2; bus.frame_size = 1'b0; bus.en = 1'b1;
      pulses = 0; hi = 0; prev_s = 1'b0; prev_w = 1'b0;
      for (int i = 0; i < 256; i++) begin
        step();
        if (prev_s && !bus.sclk && prev_w) pulses++;
        if (bus.ws_change) hi++;
        prev_s = bus.sclk;
        prev_w = bus.ws_change;
      end
      check_int("wsc_negedge_pulses", pulses, 3);
      check_int("wsc_high_cycles", hi, 12);
    end

    // randomized run against the model
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      int run_len;
      int off_len;
      bus.N = 6'($urandom_range(0, 9));
      bus.frame_size = 1'($urandom_range(0, 1));
      run_len = $urandom_range(10, 150);
      off_len = $urandom_range(1, 4);
      bus.en = 1'b1;
      for (int c = 0; c < run_len; c++) begin
        if ($urandom_range(0, 63) == 0) bus.frame_size = ~bus.frame_size;
        step();
        model_edge(1'b1, int'(bus.N), bus.frame_size);
        check3($sformatf("rand_s%0d_c%0d", seg, c), outs(), model_outs());
      end
      bus.en = 1'b0;
      for (int c = 0; c < off_len; c++) begin
        step();
        model_edge(1'b0, int'(bus.N), bus.frame_size);
        check3($sformatf("rand_off_s%0d_c%0d", seg, c), outs(), model_outs());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
